line_ilas_tx: RTL and testbench

//  JESD204B-style transmit link layer for one 2-octet/clk lane; partner of the lane-side word aligner.

---
 rtl/line_jesd_pkg.sv | 16 +
 rtl/line_sync_filter.sv | 39 +++
 rtl/line_ilas_tx.sv | 144 ++++++++++++++
 tb/tb_line_ilas_tx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/line_jesd_pkg.sv
// Shared JESD204B link-layer constants and the link state encoding (used by the transmit link
// layer and the lane-side aligner).
package line_jesd_pkg;

    localparam logic [7:0] K_K = 8'hBC;
    localparam logic [7:0] K_R = 8'h1C;
    localparam logic [7:0] K_A = 8'h7C;
    localparam logic [7:0] K_Q = 8'h9C;

    typedef enum logic [1:0] {
        ST_CGS  = 2'b00,
        ST_ILAS = 2'b01,
        ST_DATA = 2'b10
    } jesd_state_t;

endpackage

// File: rtl/line_sync_filter.sv
// SYNC~ 2-flop synchronizer plus a consecutive-low counter that requests re-sync.
// Latency: sync_s trails sync_n by 2 clk; resync_req is combinational from the registered count.
module line_sync_filter #(
    parameter int RESYNC_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_n,
    input  logic active,
    output logic sync_s,
    output logic resync_req
);

    localparam int CNT_W = $clog2(RESYNC_CYC + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_low_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_low_cnt <= '0;
        end else begin
            r_sync1 <= sync_n;
            r_sync2 <= r_sync1;
            // Only link-up states count lows; CGS or a high sample restarts the run.
            if (!active || r_sync2)
                r_low_cnt <= '0;
            else if (r_low_cnt != CNT_W'(RESYNC_CYC))
                r_low_cnt <= r_low_cnt + CNT_W'(1);
        end
    end

    assign sync_s     = r_sync2;
    assign resync_req = active && !r_sync2 && (r_low_cnt == CNT_W'(RESYNC_CYC - 1));

endmodule

// File: rtl/line_ilas_tx.sv
// JESD204B transmit link layer for one 2-octet lane: CGS, then ILAS from the next LMFC boundary, then data.
// All outputs registered; tx_data -> o is 1 clk, no backpressure beyond tx_ready=0 outside DATA.
module line_ilas_tx
    import line_jesd_pkg::*;
#(
    parameter int F          = 2,
    parameter int K          = 16,
    parameter int ILAS_MF    = 4,
    parameter int RESYNC_CYC = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sync_n,
    input  logic         lmfc_align,
    input  logic [111:0] cfg,
    input  logic [15:0]  tx_data,
    output logic         tx_ready,
    output logic [15:0]  o,
    output logic [1:0]   datak,
    output logic [1:0]   state_tst
);

    localparam int W      = F * K / 2;
    localparam int LMFC_W = $clog2(W);
    localparam int MF_W   = $clog2(ILAS_MF);

    jesd_state_t       r_state;
    jesd_state_t       w_state_nxt;
    logic [LMFC_W-1:0] r_lmfc_cnt;
    logic [MF_W-1:0]   r_mf_cnt;
    logic [MF_W-1:0]   w_mf_nxt;
    logic [15:0]       r_o;
    logic [15:0]       w_o_nxt;
    logic [1:0]        r_k;
    logic [1:0]        w_k_nxt;
    logic              r_tx_ready;

    logic              w_sync_s;
    logic              w_resync_req;
    logic              w_lmfc_last;
    logic [7:0]        w_c8;
    logic [2:0]        w_cfg_sel;
    logic              w_cfg_word_slot;
    logic [15:0]       w_cfg_word [8];

    line_sync_filter #(
        .RESYNC_CYC (RESYNC_CYC)
    ) u_sync_filter (
        .clk        (clk),
        .rst        (rst),
        .sync_n     (sync_n),
        .active     (r_state != ST_CGS),
        .sync_s     (w_sync_s),
        .resync_req (w_resync_req)
    );

    assign w_lmfc_last = (r_lmfc_cnt == LMFC_W'(W - 1));

    always_ff @(posedge clk) begin
        if (rst)
            r_lmfc_cnt <= '0;
        else if ((r_state == ST_CGS && lmfc_align) || w_lmfc_last)
            r_lmfc_cnt <= '0;
        else
            r_lmfc_cnt <= r_lmfc_cnt + LMFC_W'(1);
    end

    // Config octets travel in pairs, one pair per word on words 1..7 of the second multiframe.
    always_comb begin
        for (int i = 0; i < 7; i++)
            w_cfg_word[i] = cfg[16*i +: 16];
        w_cfg_word[7] = 16'h0000;
    end

    assign w_c8            = 8'(r_lmfc_cnt);
    assign w_cfg_sel       = 3'(r_lmfc_cnt - LMFC_W'(1));
    assign w_cfg_word_slot = (r_lmfc_cnt != '0) && (r_lmfc_cnt <= LMFC_W'(7));

    always_comb begin
        w_state_nxt = r_state;
        w_mf_nxt    = r_mf_cnt;
        w_o_nxt     = 16'h0000;
        w_k_nxt     = 2'b00;
        case (r_state)
            ST_CGS: begin
                w_o_nxt = {K_K, K_K};
                w_k_nxt = 2'b11;
                if (w_sync_s && w_lmfc_last) begin
                    w_state_nxt = ST_ILAS;
                    w_mf_nxt    = '0;
                end
            end
            ST_ILAS: begin
                w_o_nxt = {w_c8[6:0], 1'b1, w_c8[6:0], 1'b0};
                if (r_lmfc_cnt == '0) begin
                    w_o_nxt[7:0] = K_R;
                    w_k_nxt[0]   = 1'b1;
                    if (r_mf_cnt == MF_W'(1)) begin
                        w_o_nxt[15:8] = K_Q;
                        w_k_nxt[1]    = 1'b1;
                    end
                end
                if (r_mf_cnt == MF_W'(1) && w_cfg_word_slot)
                    w_o_nxt = w_cfg_word[w_cfg_sel];
                if (w_lmfc_last) begin
                    w_o_nxt[15:8] = K_A;
                    w_k_nxt[1]    = 1'b1;
                    w_mf_nxt      = r_mf_cnt + MF_W'(1);
                    if (r_mf_cnt == MF_W'(ILAS_MF - 1))
                        w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                w_o_nxt = tx_data;
                w_k_nxt = 2'b00;
            end
            default: w_state_nxt = ST_CGS;
        endcase
        if (w_resync_req)
            w_state_nxt = ST_CGS;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_CGS;
            r_mf_cnt   <= '0;
            r_o        <= 16'h0000;
            r_k        <= 2'b00;
            r_tx_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mf_cnt   <= w_mf_nxt;
            r_o        <= w_o_nxt;
            r_k        <= w_k_nxt;
            r_tx_ready <= (w_state_nxt == ST_DATA);
        end
    end

    assign o         = r_o;
    assign datak     = r_k;
    assign tx_ready  = r_tx_ready;
    assign state_tst = r_state;

endmodule

// File: tb/tb_line_ilas_tx.sv
// Self-checking bench for line_ilas_tx: CGS, ILAS content and timing, data pass-through,
// re-sync filtering, lmfc_align handling and reset in ILAS.
module tb_line_ilas_tx;
    import line_jesd_pkg::*;

    localparam int F       = 2;
    localparam int K       = 16;
    localparam int W       = F * K / 2;
    localparam int ILAS_MF = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         sync_n;
    logic         lmfc_align;
    logic [111:0] cfg;
    logic [15:0]  tx_data;
    logic         tx_ready;
    logic [15:0]  o;
    logic [1:0]   datak;
    logic [1:0]   state_tst;

    always #5 clk = ~clk;

    line_ilas_tx #(
        .F          (F),
        .K          (K),
        .ILAS_MF    (ILAS_MF),
        .RESYNC_CYC (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sync_n     (sync_n),
        .lmfc_align (lmfc_align),
        .cfg        (cfg),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .o          (o),
        .datak      (datak),
        .state_tst  (state_tst)
    );

    typedef struct packed {
        logic [15:0] o;
        logic [1:0]  k;
        logic        rdy;
        logic [1:0]  st;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          lm       = 0;
    logic [1:0]  st_model = 2'b00;
    logic [15:0] mf1_obs [W];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] ov, input logic [1:0] kv, input logic rv,
                                input logic [1:0] sv);
        exp_t e;
        e.o = ov; e.k = kv; e.rdy = rv; e.st = sv;
        return e;
    endfunction

    function automatic exp_t cgs_w(input logic [1:0] sv);
        return mk(16'hBCBC, 2'b11, 1'b0, sv);
    endfunction

    // Expected ILAS word {datak, o} for multiframe m, word c.
    function automatic logic [17:0] ilas_exp(input int m, input int c);
        logic [7:0] b0, b1;
        logic [1:0] kk;
        b0 = 8'(2 * c);
        b1 = 8'(2 * c + 1);
        kk = 2'b00;
        if (c == 0) begin b0 = K_R; kk[0] = 1'b1; end
        if (m == 1 && c == 0) begin b1 = K_Q; kk[1] = 1'b1; end
        if (m == 1 && c >= 1 && c <= 7) begin
            b0 = cfg[16*(c-1) +: 8];
            b1 = cfg[16*(c-1)+8 +: 8];
        end
        if (c == W - 1) begin b1 = K_A; kk[1] = 1'b1; end
        return {kk, b1, b0};
    endfunction

    // One clock: queue the expectation for the coming edge, then compare after it.
    task automatic cycle(input string tag, input exp_t e);
        exp_t x;
        logic was_cgs;
        was_cgs = (st_model == 2'b00);
        sb_q.push_back(e);
        @(negedge clk);
        if (rst)                        lm = 0;
        else if (was_cgs && lmfc_align) lm = 0;
        else                            lm = (lm + 1) % W;
        st_model = e.st;
        x = sb_q.pop_front();
        check({tag, ".o"},        32'(o),         32'(x.o));
        check({tag, ".datak"},    32'(datak),     32'(x.k));
        check({tag, ".tx_ready"}, 32'(tx_ready),  32'(x.rdy));
        check({tag, ".state"},    32'(state_tst), 32'(x.st));
    endtask

    // CGS words until the one at LMFC index W-1, which also moves the state to ILAS.
    task automatic until_boundary(input string tag);
        int lb;
        do begin
            lb = lm;
            cycle(tag, cgs_w((lb == W - 1) ? 2'b01 : 2'b00));
        end while (lb != W - 1);
    endtask

    task automatic run_ilas(input int n_words);
        int m, c;
        logic last;
        logic [17:0] ek;
        for (int i = 0; i < n_words; i++) begin
            m    = i / W;
            c    = i % W;
            last = (m == ILAS_MF - 1) && (c == W - 1);
            ek   = ilas_exp(m, c);
            cycle($sformatf("ilas_m%0d_c%0d", m, c),
                  mk(ek[15:0], ek[17:16], last, last ? 2'b10 : 2'b01));
            if (m == 1) mf1_obs[c] = o;
        end
    endtask

    initial begin
        rst        = 1'b1;
        sync_n     = 1'b0;
        lmfc_align = 1'b0;
        cfg        = 112'h0D0C0B0A09080706050403020100;
        tx_data    = 16'h0000;

        repeat (2) cycle("reset", mk(16'h0000, 2'b00, 1'b0, 2'b00));
        rst = 1'b0;
        repeat (50) cycle("cgs", cgs_w(2'b00));

        lmfc_align = 1'b1;
        cycle("align_cgs", cgs_w(2'b00));
        lmfc_align = 1'b0;
        check("lmfc_after_align_cgs", 32'(dut.r_lmfc_cnt), 32'(lm));
        check("lmfc_align_cgs_zero", 32'(dut.r_lmfc_cnt), 32'd0);

        while (lm != 5) cycle("cgs_wait", cgs_w(2'b00));
        sync_n = 1'b1;
        until_boundary("cgs_to_ilas");
        run_ilas(ILAS_MF * W);
        check("mf1_word0",  32'(mf1_obs[0]),  32'h9C1C);
        check("mf1_word1",  32'(mf1_obs[1]),  32'h0100);
        check("mf1_word7",  32'(mf1_obs[7]),  32'h0D0C);
        check("mf1_word15", 32'(mf1_obs[15]), 32'h7C1E);

        for (int i = 0; i < 20; i++) begin
            tx_data = 16'(i);
            cycle("data_ramp", mk(16'(i), 2'b00, 1'b1, 2'b10));
        end

        sync_n = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (i == 3) sync_n = 1'b1;
            tx_data = 16'h5A00 + 16'(i);
            cycle("short_low", mk(tx_data, 2'b00, 1'b1, 2'b10));
        end

        lmfc_align = 1'b1;
        tx_data    = 16'h1234;
        cycle("align_data", mk(16'h1234, 2'b00, 1'b1, 2'b10));
        lmfc_align = 1'b0;
        check("lmfc_after_align_data", 32'(dut.r_lmfc_cnt), 32'(lm));

        sync_n = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tx_data = 16'hA000 + 16'(i);
            cycle($sformatf("resync_e%0d", i),
                  mk(tx_data, 2'b00, (i < 6), (i < 6) ? 2'b10 : 2'b00));
        end
        sync_n = 1'b1;
        repeat (2) cycle("resync_cgs", cgs_w(2'b00));
        until_boundary("re_ilas_start");
        run_ilas(W + 5);

        rst    = 1'b1;
        sync_n = 1'b0;
        cycle("rst_in_ilas", mk(16'h0000, 2'b00, 1'b0, 2'b00));
        rst = 1'b0;
        repeat (3) cycle("cgs_after_rst", cgs_w(2'b00));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
